countdown_timer_mmss: RTL and testbench

- BCD minutes:seconds down-counter for the alarm's countdown/snooze function.
- Loads an MM:SS value and decrements once per 1 Hz tick enable.
- Signals expiry with a one-cycle pulse and a sticky flag.
- Digit outputs feed the display digit-scan mux alongside the time-of-day digits.

---
 rtl/countdown_timer_mmss_if.sv | 35 +++
 rtl/countdown_timer_mmss.sv | 139 +++++++++++++
 tb/tb_countdown_timer_mmss.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_mmss_if.sv
// Control and digit bundle for the MM:SS countdown timer.
// master: controller/bench side (drives tick/load/start/stop/ack and the ld_* digits).
// slave:  timer side (drives the current digits and the running/done/expired flags).
interface countdown_timer_mmss_if;
   logic       tick;
   logic       load;
   logic [3:0] ld_min_t;
   logic [3:0] ld_min_o;
   logic [3:0] ld_sec_t;
   logic [3:0] ld_sec_o;
   logic       start;
   logic       stop;
   logic       ack;
   logic [3:0] min_t;
   logic [3:0] min_o;
   logic [3:0] sec_t;
   logic [3:0] sec_o;
   logic       running;
   logic       done;
   logic       expired;

   modport master (
      output tick, load, start, stop, ack,
      output ld_min_t, ld_min_o, ld_sec_t, ld_sec_o,
      input  min_t, min_o, sec_t, sec_o,
      input  running, done, expired
   );

   modport slave (
      input  tick, load, start, stop, ack,
      input  ld_min_t, ld_min_o, ld_sec_t, ld_sec_o,
      output min_t, min_o, sec_t, sec_o,
      output running, done, expired
   );
endinterface

// File: rtl/countdown_timer_mmss.sv
// BCD MM:SS down-counter for the alarm countdown/snooze function.
// Ports: clk, rst (sync, active-high), bus (slave): tick/load/start/stop/ack,
//   ld_* load digits in; min_t/min_o/sec_t/sec_o digits and
//   running/done/expired flags out, all registered.
module countdown_timer_mmss #(
   parameter int MIN_TENS_MAX = 9
) (
   input logic                   clk,
   input logic                   rst,
   countdown_timer_mmss_if.slave bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_PAUSE   = 2'd2;
   localparam logic [1:0] S_EXPIRED = 2'd3;

   localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

   logic [1:0] state_q, state_d;
   logic [3:0] mt_q, mo_q, st_q, so_q;
   logic [3:0] mt_d, mo_d, st_d, so_d;
   logic       done_q, done_d;
   logic       running_q;
   logic       expired_q;

   // One-second decrement with BCD borrow chain
   logic [3:0] mt_dec, mo_dec, st_dec, so_dec;
   logic       b_so, b_st, b_mo;
   logic       cnt_zero;
   logic       dec_zero;

   function automatic logic [3:0] clamp(
      input logic [3:0] v,
      input logic [3:0] lim
   );
      return (v > lim) ? lim : v;
   endfunction

   assign cnt_zero = (mt_q == 4'd0) && (mo_q == 4'd0) &&
                     (st_q == 4'd0) && (so_q == 4'd0);

   always_comb begin
      b_so   = (so_q == 4'd0);
      so_dec = b_so ? 4'd9 : so_q - 4'd1;
      b_st   = b_so && (st_q == 4'd0);
      st_dec = st_q;
      if (b_so)
         st_dec = (st_q == 4'd0) ? 4'd5 : st_q - 4'd1;
      b_mo   = b_st && (mo_q == 4'd0);
      mo_dec = mo_q;
      if (b_st)
         mo_dec = (mo_q == 4'd0) ? 4'd9 : mo_q - 4'd1;
      // Never decremented at 00:00, so min_t cannot underflow here
      mt_dec = b_mo ? mt_q - 4'd1 : mt_q;
   end

   assign dec_zero = (mt_dec == 4'd0) && (mo_dec == 4'd0) &&
                     (st_dec == 4'd0) && (so_dec == 4'd0);

   // Priority: load > ack > stop > start > tick; inputs that do not
   // apply to the current state fall through without effect.
   always_comb begin
      state_d = state_q;
      mt_d    = mt_q;
      mo_d    = mo_q;
      st_d    = st_q;
      so_d    = so_q;
      done_d  = 1'b0;
      if (bus.load) begin
         mt_d    = clamp(bus.ld_min_t, MT_MAX);
         mo_d    = clamp(bus.ld_min_o, 4'd9);
         st_d    = clamp(bus.ld_sec_t, 4'd5);
         so_d    = clamp(bus.ld_sec_o, 4'd9);
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start && !cnt_zero)
                  state_d = S_RUN;
            end
            S_RUN: begin
               if (bus.stop) begin
                  state_d = S_PAUSE;
               end else if (bus.tick) begin
                  mt_d = mt_dec;
                  mo_d = mo_dec;
                  st_d = st_dec;
                  so_d = so_dec;
                  if (dec_zero) begin
                     state_d = S_EXPIRED;
                     done_d  = 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               if (bus.start)
                  state_d = S_RUN;
            end
            S_EXPIRED: begin
               if (bus.ack)
                  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mt_q      <= 4'd0;
         mo_q      <= 4'd0;
         st_q      <= 4'd0;
         so_q      <= 4'd0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mt_q      <= mt_d;
         mo_q      <= mo_d;
         st_q      <= st_d;
         so_q      <= so_d;
         done_q    <= done_d;
         running_q <= (state_d == S_RUN);
         expired_q <= (state_d == S_EXPIRED);
      end
   end

   assign bus.min_t   = mt_q;
   assign bus.min_o   = mo_q;
   assign bus.sec_t   = st_q;
   assign bus.sec_o   = so_q;
   assign bus.running = running_q;
   assign bus.done    = done_q;
   assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Bench for countdown_timer_mmss: directed scenarios plus random stimulus
// checked against a seconds-count reference model.
module tb_countdown_timer_mmss;

   logic clk;
   logic rst;
   countdown_timer_mmss_if bif();

   countdown_timer_mmss #(.MIN_TENS_MAX(9)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Reference model: count held as total seconds
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_PAUSE = 2;
   localparam int M_EXP  = 3;
   int m_total = 0;
   int m_st    = M_IDLE;
   bit m_done  = 0;
   int l_mt, l_mo, l_st, l_so;

   function automatic int lim(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [18:0] exp_vec();
      int mm;
      int ss;
      mm = m_total / 60;
      ss = m_total % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
              m_st == M_RUN, m_done, m_st == M_EXP};
   endfunction

   function automatic logic [18:0] obs();
      return {bif.min_t, bif.min_o, bif.sec_t, bif.sec_o,
              bif.running, bif.done, bif.expired};
   endfunction

   function automatic logic [15:0] digs();
      return {bif.min_t, bif.min_o, bif.sec_t, bif.sec_o};
   endfunction

   task automatic model_step(input bit r, ld, ak, sp, st, tk);
      m_done = 0;
      if (r) begin
         m_total = 0;
         m_st = M_IDLE;
      end else if (ld) begin
         m_total = (lim(l_mt, 9) * 10 + lim(l_mo, 9)) * 60 +
                   lim(l_st, 5) * 10 + lim(l_so, 9);
         m_st = M_IDLE;
      end else begin
         case (m_st)
            M_IDLE:  if (st && m_total != 0) m_st = M_RUN;
            M_RUN: begin
               if (sp) m_st = M_PAUSE;
               else if (tk) begin
                  m_total = m_total - 1;
                  if (m_total == 0) begin
                     m_st = M_EXP;
                     m_done = 1;
                  end
               end
            end
            M_PAUSE: if (st) m_st = M_RUN;
            default: if (ak) m_st = M_IDLE;
         endcase
      end
   endtask

   task automatic set_ld(input int mt, mo, st, so);
      l_mt = mt; l_mo = mo; l_st = st; l_so = so;
      bif.ld_min_t = 4'(mt);
      bif.ld_min_o = 4'(mo);
      bif.ld_sec_t = 4'(st);
      bif.ld_sec_o = 4'(so);
   endtask

   // Drive one cycle of inputs, clock, update model, settle past the edge
   task automatic cyc(input bit r, ld, ak, sp, st, tk);
      rst = r;
      bif.load = ld;
      bif.ack = ak;
      bif.stop = sp;
      bif.start = st;
      bif.tick = tk;
      @(posedge clk);
      model_step(r, ld, ak, sp, st, tk);
      #1;
      rst = 0;
      bif.load = 0;
      bif.ack = 0;
      bif.stop = 0;
      bif.start = 0;
      bif.tick = 0;
   endtask

   task automatic test_reset();
      set_ld(0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== 19'h0) begin
         fails++;
         $display("FAIL reset: got %h want %h", obs(), 19'h0);
      end
   endtask

   task automatic test_expiry();
      logic [15:0] want [3];
      want[0] = 16'h0002; want[1] = 16'h0001; want[2] = 16'h0000;
      set_ld(0, 0, 0, 3);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 1);
         checks++;
         if (digs() !== want[i] || bif.done !== (i == 2)) begin
            fails++;
            $display("FAIL expiry_tick%0d: got %h done=%b want %h done=%b",
                     i, digs(), bif.done, want[i], i == 2);
         end
      end
      cyc(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== exp_vec() || {bif.running, bif.done, bif.expired} !== 3'b001) begin
         fails++;
         $display("FAIL expiry_after: got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_borrow();
      set_ld(1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1);
      checks++;
      if (digs() !== 16'h0959 || obs() !== exp_vec()) begin
         fails++;
         $display("FAIL borrow_10m: got %h want %h", obs(), exp_vec());
      end
      set_ld(0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1);
      checks++;
      if (digs() !== 16'h0059 || obs() !== exp_vec()) begin
         fails++;
         $display("FAIL borrow_1m: got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_pause();
      set_ld(0, 0, 0, 5);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0, 1);
      checks++;
      if (digs() !== 16'h0004 || bif.running !== 1'b0) begin
         fails++;
         $display("FAIL pause_stop: got %h run=%b want 0004 run=0", digs(), bif.running);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 1);
         checks++;
         if (obs() !== exp_vec()) begin
            fails++;
            $display("FAIL pause_hold%0d: got %h want %h", i, obs(), exp_vec());
         end
      end
      cyc(0, 0, 0, 0, 1, 1);
      checks++;
      if (digs() !== 16'h0004 || bif.running !== 1'b1) begin
         fails++;
         $display("FAIL pause_resume: got %h run=%b want 0004 run=1", digs(), bif.running);
      end
      cyc(0, 0, 0, 0, 0, 1);
      checks++;
      if (digs() !== 16'h0003 || obs() !== exp_vec()) begin
         fails++;
         $display("FAIL pause_tick: got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_clamp();
      set_ld(11, 4, 7, 12);
      cyc(0, 1, 0, 0, 0, 1);
      checks++;
      if (digs() !== 16'h9459 || obs() !== exp_vec()) begin
         fails++;
         $display("FAIL clamp: got %h want %h", obs(), exp_vec());
      end
      set_ld(0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1);
      checks++;
      if (obs() !== 19'h0) begin
         fails++;
         $display("FAIL zero_start: got %h want %h", obs(), 19'h0);
      end
   endtask

   task automatic test_expired();
      set_ld(0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0, 1);
      checks++;
      if (obs() !== 19'h00001 || obs() !== exp_vec()) begin
         fails++;
         $display("FAIL expired_hold: got %h want %h", obs(), 19'h00001);
      end
      cyc(0, 0, 1, 0, 0, 0);
      checks++;
      if (obs() !== 19'h0) begin
         fails++;
         $display("FAIL ack: got %h want %h", obs(), 19'h0);
      end
      set_ld(0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1);
      checks++;
      if (obs() !== 19'h00003) begin
         fails++;
         $display("FAIL reexpire: got %h want %h", obs(), 19'h00003);
      end
   endtask

   task automatic test_rst_mid_run();
      set_ld(0, 5, 3, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      set_ld(1, 2, 3, 4);
      cyc(1, 1, 0, 0, 0, 1);
      checks++;
      if (obs() !== 19'h0) begin
         fails++;
         $display("FAIL rst_mid_run: got %h want %h", obs(), 19'h0);
      end
      set_ld(0, 5, 3, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      #2 rst = 1;
      #2 rst = 0;
      cyc(0, 0, 0, 0, 0, 1);
      checks++;
      if (digs() !== 16'h0529 || obs() !== exp_vec()) begin
         fails++;
         $display("FAIL rst_glitch: got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_random();
      bit r, ld, ak, sp, st, tk;
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 199) == 0);
         ld = ($urandom_range(0, 29) == 0);
         sp = ($urandom_range(0, 14) == 0);
         tk = ($urandom_range(0, 9) < 5);
         st = (m_st != M_RUN) && ($urandom_range(0, 6) == 0);
         ak = (m_st == M_EXP) && ($urandom_range(0, 9) == 0);
         set_ld(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0,
                $urandom_range(0, 7), $urandom_range(0, 15));
         cyc(r, ld, ak, sp, st, tk);
         checks++;
         if (obs() !== exp_vec()) begin
            fails++;
            $display("FAIL random_%0d: got %h want %h", n, obs(), exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bif.tick = 0;
      bif.load = 0;
      bif.start = 0;
      bif.stop = 0;
      bif.ack = 0;
      set_ld(0, 0, 0, 0);
      test_reset();
      test_expiry();
      test_borrow();
      test_pause();
      test_clamp();
      test_expired();
      test_rst_mid_run();
      test_random();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
